// File: rtl/decode_issue_stage.sv
// MIPS decode/issue stage: decodes IF/ID, detects RAW hazards against EX/MEM, and fills ID/EX.
// Optional operand forwarding is enabled by defining FORWARD_EN.
module decode_issue_stage (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        IfValid,
    input  logic [31:0] IfInstr,
    input  logic [31:0] IfPC,
    input  logic        Flush,
    output logic        Stall,
    output logic [4:0]  ReadRegister1,
    output logic [4:0]  ReadRegister2,
    input  logic [31:0] ReadData1,
    input  logic [31:0] ReadData2,
    input  logic        MemRegWrite,
    input  logic [4:0]  MemDest,
    input  logic [31:0] MemResult,
    output logic        ExValid,
    output logic        ExRegWrite,
    output logic        ExMemRead,
    output logic        ExMemWrite,
    output logic        ExAluSrc,
    output logic [2:0]  ExAluOp,
    output logic [4:0]  ExDest,
    output logic [31:0] ExOperandA,
    output logic [31:0] ExOperandB,
    output logic [31:0] ExImm,
    output logic [31:0] ExPC,
    output logic        ExFwdA,
    output logic        ExFwdB,
    output logic [15:0] StallCount
);

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;

    logic        dec_reg_write, dec_mem_read, dec_mem_write, dec_alu_src;
    logic [2:0]  dec_alu_op;
    logic [4:0]  dec_dest;
    logic        uses_rs, uses_rt;
    logic [31:0] dec_imm;

    logic        ex_valid_q, ex_reg_write_q, ex_mem_read_q, ex_mem_write_q, ex_alu_src_q;
    logic [2:0]  ex_alu_op_q;
    logic [4:0]  ex_dest_q;
    logic [31:0] ex_operand_a_q, ex_operand_b_q, ex_imm_q, ex_pc_q;
    logic        ex_fwd_a_q, ex_fwd_b_q;
    logic [15:0] stall_count_q;

    logic        ex_valid_d, ex_reg_write_d, ex_mem_read_d, ex_mem_write_d, ex_alu_src_d;
    logic [2:0]  ex_alu_op_d;
    logic [4:0]  ex_dest_d;
    logic [31:0] ex_operand_a_d, ex_operand_b_d, ex_imm_d, ex_pc_d;
    logic        ex_fwd_a_d, ex_fwd_b_d;
    logic [15:0] stall_count_d;

    logic        ex_match_a, ex_match_b, mem_match_a, mem_match_b;
    logic        hazard, issue;
    logic        fwd_a, fwd_b;
    logic [31:0] operand_a, operand_b;

    assign opcode        = IfInstr[31:26];
    assign rs            = IfInstr[25:21];
    assign rt            = IfInstr[20:16];
    assign rd            = IfInstr[15:11];
    assign funct         = IfInstr[5:0];
    assign imm16         = IfInstr[15:0];
    assign ReadRegister1 = rs;
    assign ReadRegister2 = rt;

    always_comb begin
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_alu_src   = 1'b0;
        dec_alu_op    = ALU_ADD;
        dec_dest      = 5'd0;
        uses_rs       = 1'b0;
        uses_rt       = 1'b0;
        dec_imm       = {{16{imm16[15]}}, imm16};
        case (opcode)
            6'h00: begin
                // Unknown funct falls through as a NOP with no register use.
                if (funct == 6'h20 || funct == 6'h22 || funct == 6'h24 ||
                    funct == 6'h25 || funct == 6'h2A) begin
                    dec_reg_write = 1'b1;
                    dec_dest      = rd;
                    uses_rs       = 1'b1;
                    uses_rt       = 1'b1;
                    case (funct)
                        6'h22:   dec_alu_op = ALU_SUB;
                        6'h24:   dec_alu_op = ALU_AND;
                        6'h25:   dec_alu_op = ALU_OR;
                        6'h2A:   dec_alu_op = ALU_SLT;
                        default: dec_alu_op = ALU_ADD;
                    endcase
                end
            end
            6'h08: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_dest      = rt;
                uses_rs       = 1'b1;
            end
            6'h0D: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_alu_op    = ALU_OR;
                dec_dest      = rt;
                uses_rs       = 1'b1;
                dec_imm       = {16'd0, imm16};
            end
            6'h23: begin
                dec_reg_write = 1'b1;
                dec_mem_read  = 1'b1;
                dec_alu_src   = 1'b1;
                dec_dest      = rt;
                uses_rs       = 1'b1;
            end
            6'h2B: begin
                dec_mem_write = 1'b1;
                dec_alu_src   = 1'b1;
                uses_rs       = 1'b1;
                uses_rt       = 1'b1;
            end
            default: ;
        endcase
    end

    // A producer matches only if it really writes a non-zero register.
    assign ex_match_a  = uses_rs && (rs != 5'd0) && ex_valid_q && ex_reg_write_q && (rs == ex_dest_q);
    assign ex_match_b  = uses_rt && (rt != 5'd0) && ex_valid_q && ex_reg_write_q && (rt == ex_dest_q);
    assign mem_match_a = uses_rs && (rs != 5'd0) && MemRegWrite && (rs == MemDest);
    assign mem_match_b = uses_rt && (rt != 5'd0) && MemRegWrite && (rt == MemDest);

`ifdef FORWARD_EN
    // EX results are substituted inside EX next cycle; only a load in EX is too late.
    assign hazard    = (ex_match_a || ex_match_b) && ex_mem_read_q;
    assign fwd_a     = ex_match_a && !ex_mem_read_q;
    assign fwd_b     = ex_match_b && !ex_mem_read_q;
    assign operand_a = (!ex_match_a && mem_match_a) ? MemResult : ReadData1;
    assign operand_b = (!ex_match_b && mem_match_b) ? MemResult : ReadData2;
`else
    logic unused_mem_result;
    assign unused_mem_result = ^MemResult;
    assign hazard    = ex_match_a || ex_match_b || mem_match_a || mem_match_b;
    assign fwd_a     = 1'b0;
    assign fwd_b     = 1'b0;
    assign operand_a = ReadData1;
    assign operand_b = ReadData2;
`endif

    // Handshake: IF/ID is consumed on a posedge when IfValid && !Stall; Flush squashes it
    // instead. While Stall=1 upstream must hold PC and IF/ID unchanged.
    assign Stall = !Reset && IfValid && !Flush && hazard;
    assign issue = IfValid && !Flush && !hazard;

    always_comb begin
        ex_valid_d     = 1'b0;
        ex_reg_write_d = 1'b0;
        ex_mem_read_d  = 1'b0;
        ex_mem_write_d = 1'b0;
        ex_alu_src_d   = 1'b0;
        ex_alu_op_d    = 3'd0;
        ex_dest_d      = 5'd0;
        ex_operand_a_d = 32'd0;
        ex_operand_b_d = 32'd0;
        ex_imm_d       = 32'd0;
        ex_pc_d        = 32'd0;
        ex_fwd_a_d     = 1'b0;
        ex_fwd_b_d     = 1'b0;
        if (issue) begin
            ex_valid_d     = 1'b1;
            ex_reg_write_d = dec_reg_write && (dec_dest != 5'd0);
            ex_mem_read_d  = dec_mem_read;
            ex_mem_write_d = dec_mem_write;
            ex_alu_src_d   = dec_alu_src;
            ex_alu_op_d    = dec_alu_op;
            ex_dest_d      = dec_dest;
            ex_operand_a_d = operand_a;
            ex_operand_b_d = operand_b;
            ex_imm_d       = dec_imm;
            ex_pc_d        = IfPC;
            ex_fwd_a_d     = fwd_a;
            ex_fwd_b_d     = fwd_b;
        end
        stall_count_d = stall_count_q;
        if (Stall && (stall_count_q != 16'hFFFF)) stall_count_d = stall_count_q + 16'd1;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ex_valid_q     <= 1'b0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_mem_write_q <= 1'b0;
            ex_alu_src_q   <= 1'b0;
            ex_alu_op_q    <= 3'd0;
            ex_dest_q      <= 5'd0;
            ex_operand_a_q <= 32'd0;
            ex_operand_b_q <= 32'd0;
            ex_imm_q       <= 32'd0;
            ex_pc_q        <= 32'd0;
            ex_fwd_a_q     <= 1'b0;
            ex_fwd_b_q     <= 1'b0;
            stall_count_q  <= 16'd0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_reg_write_q <= ex_reg_write_d;
            ex_mem_read_q  <= ex_mem_read_d;
            ex_mem_write_q <= ex_mem_write_d;
            ex_alu_src_q   <= ex_alu_src_d;
            ex_alu_op_q    <= ex_alu_op_d;
            ex_dest_q      <= ex_dest_d;
            ex_operand_a_q <= ex_operand_a_d;
            ex_operand_b_q <= ex_operand_b_d;
            ex_imm_q       <= ex_imm_d;
            ex_pc_q        <= ex_pc_d;
            ex_fwd_a_q     <= ex_fwd_a_d;
            ex_fwd_b_q     <= ex_fwd_b_d;
            stall_count_q  <= stall_count_d;
        end
    end

    assign ExValid    = ex_valid_q;
    assign ExRegWrite = ex_reg_write_q;
    assign ExMemRead  = ex_mem_read_q;
    assign ExMemWrite = ex_mem_write_q;
    assign ExAluSrc   = ex_alu_src_q;
    assign ExAluOp    = ex_alu_op_q;
    assign ExDest     = ex_dest_q;
    assign ExOperandA = ex_operand_a_q;
    assign ExOperandB = ex_operand_b_q;
    assign ExImm      = ex_imm_q;
    assign ExPC       = ex_pc_q;
    assign ExFwdA     = ex_fwd_a_q;
    assign ExFwdB     = ex_fwd_b_q;
    assign StallCount = stall_count_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage; expected ID/EX contents are queued per step and
// compared one cycle later. Expectations follow FORWARD_EN when it is defined.
module tb_decode_issue_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid, flush;
  logic [31:0] if_instr, if_pc;
  logic        stall;
  logic [4:0]  rr1, rr2;
  logic [31:0] rd1, rd2;
  logic        mem_reg_write;
  logic [4:0]  mem_dest;
  logic [31:0] mem_result;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src;
  logic [2:0]  ex_alu_op;
  logic [4:0]  ex_dest;
  logic [31:0] ex_op_a, ex_op_b, ex_imm, ex_pc;
  logic        ex_fwd_a, ex_fwd_b;
  logic [15:0] stall_count;

  typedef struct packed {
    logic        stall, valid, rw, mr, mw, asrc;
    logic [2:0]  op;
    logic [4:0]  dest;
    logic [31:0] opa, opb, imm, pc;
    logic        fa, fb, chk_data, chk_imm;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_cnt = 16'd0;

  decode_issue_stage dut (
    .Clk(clk), .Reset(rst), .IfValid(if_valid), .IfInstr(if_instr), .IfPC(if_pc),
    .Flush(flush), .Stall(stall), .ReadRegister1(rr1), .ReadRegister2(rr2),
    .ReadData1(rd1), .ReadData2(rd2), .MemRegWrite(mem_reg_write), .MemDest(mem_dest),
    .MemResult(mem_result), .ExValid(ex_valid), .ExRegWrite(ex_reg_write),
    .ExMemRead(ex_mem_read), .ExMemWrite(ex_mem_write), .ExAluSrc(ex_alu_src),
    .ExAluOp(ex_alu_op), .ExDest(ex_dest), .ExOperandA(ex_op_a), .ExOperandB(ex_op_b),
    .ExImm(ex_imm), .ExPC(ex_pc), .ExFwdA(ex_fwd_a), .ExFwdB(ex_fwd_b),
    .StallCount(stall_count)
  );

  always #5 clk = ~clk;

  // Register file model: distinct non-zero contents, $0 hard-wired to zero.
  function automatic logic [31:0] rf(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : (32'hCAFE_0000 | {27'd0, a});
  endfunction

  assign rd1 = rf(rr1);
  assign rd2 = rf(rr2);

  function automatic logic [31:0] r_ins(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_bub(input logic st);
    exp_t e;
    e = '0;
    e.stall = st;
    if (st && exp_cnt != 16'hFFFF) exp_cnt++;
    e.cnt = exp_cnt;
    exp_q.push_back(e);
  endtask

  task automatic exp_iss(input logic rw, mr, mw, asrc, input logic [2:0] op,
                         input logic [4:0] dest, input logic [31:0] opa, opb, imm, pc,
                         input logic fa, fb, ci);
    exp_t e;
    e = '{stall: 1'b0, valid: 1'b1, rw: rw, mr: mr, mw: mw, asrc: asrc, op: op,
          dest: dest, opa: opa, opb: opb, imm: imm, pc: pc, fa: fa, fb: fb,
          chk_data: 1'b1, chk_imm: ci, cnt: exp_cnt};
    exp_q.push_back(e);
  endtask

  task automatic exp_nop();
    exp_t e;
    e = '0;
    e.valid = 1'b1;
    e.cnt = exp_cnt;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic fl, input logic mrw, input logic [4:0] md,
                      input logic [31:0] mres);
    exp_t e;
    @(negedge clk);
    if_valid = v; if_instr = ins; if_pc = pc; flush = fl;
    mem_reg_write = mrw; mem_dest = md; mem_result = mres;
    #1;
    e = exp_q.pop_front();
    chk("stall", stall, e.stall);
    chk("read_reg1", rr1, ins[25:21]);
    chk("read_reg2", rr2, ins[20:16]);
    @(posedge clk);
    #1;
    chk("ex_valid", ex_valid, e.valid);
    chk("ex_reg_write", ex_reg_write, e.rw);
    chk("ex_mem_read", ex_mem_read, e.mr);
    chk("ex_mem_write", ex_mem_write, e.mw);
    chk("ex_alu_src", ex_alu_src, e.asrc);
    chk("ex_alu_op", ex_alu_op, e.op);
    chk("ex_fwd_a", ex_fwd_a, e.fa);
    chk("ex_fwd_b", ex_fwd_b, e.fb);
    chk("stall_count", stall_count, e.cnt);
    if (e.chk_data) begin
      chk("ex_dest", ex_dest, e.dest);
      chk("ex_operand_a", ex_op_a, e.opa);
      chk("ex_operand_b", ex_op_b, e.opb);
      chk("ex_pc", ex_pc, e.pc);
    end
    if (e.chk_imm) chk("ex_imm", ex_imm, e.imm);
  endtask

  task automatic drain();
    repeat (2) begin
      exp_bub(1'b0);
      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    end
  endtask

  task automatic check_reset_zero();
    chk("rst_stall", stall, 0);
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_reg_write", ex_reg_write, 0);
    chk("rst_ex_mem_read", ex_mem_read, 0);
    chk("rst_ex_mem_write", ex_mem_write, 0);
    chk("rst_ex_alu_src", ex_alu_src, 0);
    chk("rst_ex_alu_op", ex_alu_op, 0);
    chk("rst_ex_dest", ex_dest, 0);
    chk("rst_ex_operand_a", ex_op_a, 0);
    chk("rst_ex_operand_b", ex_op_b, 0);
    chk("rst_ex_imm", ex_imm, 0);
    chk("rst_ex_pc", ex_pc, 0);
    chk("rst_ex_fwd_a", ex_fwd_a, 0);
    chk("rst_ex_fwd_b", ex_fwd_b, 0);
    chk("rst_stall_count", stall_count, 0);
  endtask

  initial begin
    logic [31:0] lw3, add4, add5, sub6;
    lw3  = i_ins(6'h23, 5'd0, 5'd3, 16'd0);
    add4 = r_ins(5'd3, 5'd3, 5'd4, 6'h20);
    add5 = r_ins(5'd1, 5'd2, 5'd5, 6'h20);
    sub6 = r_ins(5'd5, 5'd0, 5'd6, 6'h22);

    // Clock/reset: hold a hazard-looking MEM producer while in reset.
    rst = 1'b1; if_valid = 1'b1; if_instr = add4; if_pc = 32'd0; flush = 1'b0;
    mem_reg_write = 1'b1; mem_dest = 5'd3; mem_result = 32'd0;
    #1;
    check_reset_zero();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; if_valid = 1'b0; mem_reg_write = 1'b0; mem_dest = 5'd0;

    // Independent ops: ADDI $1,$0,5 then ORI $2,$0,3.
    exp_iss(1, 0, 0, 1, 3'd0, 5'd1, 32'd0, rf(5'd1), 32'd5, 32'd4, 0, 0, 1);
    step(1, i_ins(6'h08, 5'd0, 5'd1, 16'd5), 32'd4, 0, 0, 5'd0, 32'd0);
    exp_iss(1, 0, 0, 1, 3'd3, 5'd2, 32'd0, rf(5'd2), 32'd3, 32'd8, 0, 0, 1);
    step(1, i_ins(6'h0D, 5'd0, 5'd2, 16'd3), 32'd8, 0, 1, 5'd1, 32'd5);
    drain();

    // Load-use: LW $3,0($0) then ADD $4,$3,$3.
    exp_iss(1, 1, 0, 1, 3'd0, 5'd3, 32'd0, rf(5'd3), 32'd0, 32'd12, 0, 0, 1);
    step(1, lw3, 32'd12, 0, 0, 5'd0, 32'd0);
    exp_bub(1);
    step(1, add4, 32'd16, 0, 0, 5'd0, 32'd0);
`ifdef FORWARD_EN
    exp_iss(1, 0, 0, 0, 3'd0, 5'd4, 32'h77, 32'h77, 32'd0, 32'd16, 0, 0, 0);
    step(1, add4, 32'd16, 0, 1, 5'd3, 32'h77);
    chk("load_use_count", stall_count, 1);
`else
    exp_bub(1);
    step(1, add4, 32'd16, 0, 1, 5'd3, 32'h77);
    exp_iss(1, 0, 0, 0, 3'd0, 5'd4, rf(5'd3), rf(5'd3), 32'd0, 32'd16, 0, 0, 0);
    step(1, add4, 32'd16, 0, 0, 5'd0, 32'd0);
    chk("load_use_count", stall_count, 2);
`endif
    drain();

    // ALU RAW: ADD $5,$1,$2 then SUB $6,$5,$0.
    exp_iss(1, 0, 0, 0, 3'd0, 5'd5, rf(5'd1), rf(5'd2), 32'd0, 32'd20, 0, 0, 0);
    step(1, add5, 32'd20, 0, 0, 5'd0, 32'd0);
`ifdef FORWARD_EN
    exp_iss(1, 0, 0, 0, 3'd1, 5'd6, rf(5'd5), 32'd0, 32'd0, 32'd24, 1, 0, 0);
    step(1, sub6, 32'd24, 0, 0, 5'd0, 32'd0);
`else
    exp_bub(1);
    step(1, sub6, 32'd24, 0, 0, 5'd0, 32'd0);
    exp_bub(1);
    step(1, sub6, 32'd24, 0, 1, 5'd5, 32'h55);
    exp_iss(1, 0, 0, 0, 3'd1, 5'd6, rf(5'd5), 32'd0, 32'd0, 32'd24, 0, 0, 0);
    step(1, sub6, 32'd24, 0, 0, 5'd0, 32'd0);
`endif
    drain();

    // Flush in the load-use stall cycle: no stall, bubble, count unchanged.
    exp_iss(1, 1, 0, 1, 3'd0, 5'd3, 32'd0, rf(5'd3), 32'd0, 32'd28, 0, 0, 1);
    step(1, lw3, 32'd28, 0, 0, 5'd0, 32'd0);
    exp_bub(0);
    step(1, add4, 32'd32, 1, 0, 5'd0, 32'd0);
    drain();

    // Zero-register source: ADD $0,$1,$1 then ADD $7,$0,$0.
    exp_iss(0, 0, 0, 0, 3'd0, 5'd0, rf(5'd1), rf(5'd1), 32'd0, 32'd36, 0, 0, 0);
    step(1, r_ins(5'd1, 5'd1, 5'd0, 6'h20), 32'd36, 0, 0, 5'd0, 32'd0);
    exp_iss(1, 0, 0, 0, 3'd0, 5'd7, 32'd0, 32'd0, 32'd0, 32'd40, 0, 0, 0);
    step(1, r_ins(5'd0, 5'd0, 5'd7, 6'h20), 32'd40, 0, 0, 5'd0, 32'd0);
    drain();

    // Remaining decode space: AND/OR/SLT, immediate extension, SW, NOPs.
    exp_iss(1, 0, 0, 0, 3'd2, 5'd8, rf(5'd1), rf(5'd2), 32'd0, 32'd44, 0, 0, 0);
    step(1, r_ins(5'd1, 5'd2, 5'd8, 6'h24), 32'd44, 0, 0, 5'd0, 32'd0);
    exp_iss(1, 0, 0, 0, 3'd3, 5'd9, rf(5'd3), rf(5'd4), 32'd0, 32'd48, 0, 0, 0);
    step(1, r_ins(5'd3, 5'd4, 5'd9, 6'h25), 32'd48, 0, 0, 5'd0, 32'd0);
    exp_iss(1, 0, 0, 0, 3'd4, 5'd10, rf(5'd5), rf(5'd6), 32'd0, 32'd52, 0, 0, 0);
    step(1, r_ins(5'd5, 5'd6, 5'd10, 6'h2A), 32'd52, 0, 0, 5'd0, 32'd0);
    exp_iss(1, 0, 0, 1, 3'd0, 5'd11, rf(5'd12), rf(5'd11), 32'hFFFF_FFFC, 32'd56, 0, 0, 1);
    step(1, i_ins(6'h08, 5'd12, 5'd11, 16'hFFFC), 32'd56, 0, 0, 5'd0, 32'd0);
    exp_iss(1, 0, 0, 1, 3'd3, 5'd13, rf(5'd14), rf(5'd13), 32'h0000_8000, 32'd60, 0, 0, 1);
    step(1, i_ins(6'h0D, 5'd14, 5'd13, 16'h8000), 32'd60, 0, 0, 5'd0, 32'd0);
    exp_iss(0, 0, 1, 1, 3'd0, 5'd0, rf(5'd1), rf(5'd2), 32'd8, 32'd64, 0, 0, 1);
    step(1, i_ins(6'h2B, 5'd1, 5'd2, 16'd8), 32'd64, 0, 0, 5'd0, 32'd0);
    exp_nop();
    step(1, i_ins(6'h3F, 5'd1, 5'd2, 16'd8), 32'd68, 0, 0, 5'd0, 32'd0);
    exp_nop();
    step(1, r_ins(5'd1, 5'd2, 5'd3, 6'h21), 32'd72, 0, 0, 5'd0, 32'd0);
    drain();

    // Reset asserted in the middle of a load-use stall.
    exp_iss(1, 1, 0, 1, 3'd0, 5'd3, 32'd0, rf(5'd3), 32'd0, 32'd76, 0, 0, 1);
    step(1, lw3, 32'd76, 0, 0, 5'd0, 32'd0);
    @(negedge clk);
    if_instr = add4; if_pc = 32'd80;
    #1;
    chk("pre_reset_stall", stall, 1);
    rst = 1'b1;
    #1;
    check_reset_zero();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 16'd0;
    exp_iss(1, 0, 0, 0, 3'd0, 5'd4, rf(5'd3), rf(5'd3), 32'd0, 32'd80, 0, 0, 0);
    step(1, add4, 32'd80, 0, 0, 5'd0, 32'd0);
    drain();

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/decode_issue_stage.md
# decode_issue_stage

Instruction decode and issue stage of the pipelined MIPS core. It decodes the IF/ID instruction, drives the register file's two asynchronous read addresses, and resolves read-after-write hazards against the EX and MEM stages by stalling, or by forwarding when configured. Results are latched into the ID/EX pipeline register. It sits between the IF/ID register and the EX stage, wrapped around the register file's read ports.

## Interface
- No parameters. Widths are fixed at 32-bit data and 5-bit register addresses.
- Clk  in  1  pipeline clock; ID/EX captures on posedge.
- Reset  in  1  asynchronous, active-high; clears ID/EX and the stall counter.
- IfValid  in  1  IF/ID holds a valid instruction.
- IfInstr  in  32  IF/ID instruction.
- IfPC  in  32  IF/ID PC+4.
- Flush  in  1  squash the instruction currently in ID.
- Stall  out  1  hold PC and IF/ID this cycle; combinational.
- ReadRegister1, ReadRegister2  out  5  to register file; IfInstr[25:21] and IfInstr[20:16], combinational.
- ReadData1, ReadData2  in  32  register file read data.
- MemRegWrite  in  1  EX/MEM instruction writes a register.
- MemDest  in  5  EX/MEM destination.
- MemResult  in  32  EX/MEM ALU result.
- ExValid, ExRegWrite, ExMemRead, ExMemWrite, ExAluSrc  out  1 each  ID/EX control.
- ExAluOp  out  3  ADD=0, SUB=1, AND=2, OR=3, SLT=4.
- ExDest  out  5  destination register.
- ExOperandA, ExOperandB, ExImm, ExPC  out  32  rs value, rt value, extended immediate, PC+4.
- ExFwdA, ExFwdB  out  1 each  EX must substitute MemResult for operand A/B.
- StallCount  out  16  saturating count of stall cycles.

## Operation
- Decode, by opcode:
  - 0x00 R-type, by funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT. Dest is rd; uses rs and rt.
  - 0x08 ADDI: sign-extended immediate, ADD. Dest is rt; uses rs.
  - 0x0D ORI: zero-extended immediate, OR. Dest is rt; uses rs.
  - 0x23 LW: sign-extended immediate, ADD, MemRead. Dest is rt; uses rs.
  - 0x2B SW: sign-extended immediate, ADD, MemWrite. No dest; uses rs and rt.
  - Any other opcode or funct: issued valid with all write, read and memory controls 0 (a NOP).
- ExAluSrc is 1 for I-types. ExRegWrite is forced 0 when the destination is 0.
- Source match: the source is used, is non-zero, and equals the producer's destination with the producer's RegWrite set. The EX producer is the current ID/EX contents with ExValid=1.
- The write-back stage needs no hazard handling: the register file writes on the falling edge, so reads in the second half-cycle see the new value.
- Stall condition: IfValid & !Flush & hazard.
- On Stall, ID/EX captures a bubble: ExValid=0 and all controls 0. Upstream holds the instruction in IF/ID.
- On Flush, ID/EX captures a bubble and Stall=0. Flush has priority over hazard.
- IfValid=0 captures a bubble.
- StallCount increments on every cycle with Stall=1 and saturates at 0xFFFF.

## Timing
- Decode, hazard detection, Stall and ReadRegister are combinational within the cycle.
- ID/EX updates on posedge Clk. Issue latency from IF/ID to ID/EX is one cycle.
- Reset value of every Ex* output, ExFwdA/B and StallCount is 0. Stall is forced 0 while Reset=1.
- Reset deasserted mid-stall: the next cycle re-evaluates hazards from the cleared ID/EX.
- A stall resolves on the first cycle the producer no longer matches. The instruction then issues with no duplicate issue.

## Configuration
- FORWARD_EN defined:
  - MEM match: the operand captures MemResult instead of ReadData.
  - EX match with ExMemRead=0: no stall. ExFwdA/ExFwdB are registered as 1.
  - EX match with ExMemRead=1: stall exactly one cycle (load-use).
  - The EX match is checked before the MEM match.
- FORWARD_EN undefined: any EX or MEM match stalls. ExFwdA/ExFwdB are tied to 0.

## Test plan
- Reset mid-run: every Ex* output, StallCount and Stall read 0 while Reset=1.
- Independent ops: ADDI $1,$0,5 then ORI $2,$0,3. Both issue back-to-back with ExImm=5 and 3, and no stall.
- Load-use: LW $3,0($0) then ADD $4,$3,$3.
  - FORWARD_EN: one stall cycle and one bubble. StallCount=1.
  - Without FORWARD_EN: two stall cycles. StallCount=2.
- ALU RAW: ADD $5,$1,$2 then SUB $6,$5,$0.
  - FORWARD_EN: no stall, ExFwdA=1, ExFwdB=0.
  - Without FORWARD_EN: two stall cycles.
- Flush during a load-use stall: Stall=0, a bubble is issued, and StallCount is unchanged that cycle.
- Zero-register source: ADD $0,$1,$1 then ADD $7,$0,$0. No stall, ExRegWrite=0 for the first instruction, and ExOperandA=0 for the second.
